// File: rtl/lut_mult_pkg.sv
// lut_mult_pkg -- shared definitions for the LUT multiply-accumulate slice.
//
// Contents:
//   PROD_W              width of one product from the 8x8 LUT multiplier
//   N_TERMS_MIN/MAX     legal range of products summed per frame
//   ACC_W_MIN/MAX       legal range of the accumulator width
//   CNT_W               width of the per-frame term counter (holds N_TERMS_MAX)
//   state_t             accumulator FSM states (IDLE / ACCUM / HOLD)
package lut_mult_pkg;

  localparam int PROD_W      = 16;
  localparam int N_TERMS_MIN = 1;
  localparam int N_TERMS_MAX = 255;
  localparam int ACC_W_MIN   = 16;
  localparam int ACC_W_MAX   = 32;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/lut_mac_addsat.sv
// lut_mac_addsat -- combinational ACC_W-bit adder of accumulator + product.
//
// Build option: LUT_MAC_SAT_EN
//   undefined: sum wraps modulo 2^ACC_W (no clamp logic is built)
//   defined:   sum clamps to all-ones on a carry out
//
// Ports:
//   acc    [ACC_W-1:0]  current accumulator value
//   prod   [PROD_W-1:0] unsigned product, zero-extended before the add
//   sum    [ACC_W-1:0]  next accumulator value (wrapped or clamped)
//   carry               carry out of bit ACC_W-1
module lut_mac_addsat
  import lut_mult_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw   = {1'b0, acc} + (ACC_W + 1)'(prod);
    carry = raw[ACC_W];
`ifdef LUT_MAC_SAT_EN
    // Once clamped the accumulator is all-ones, so any further non-zero
    // product carries again and keeps it pinned; a zero product leaves it
    // unchanged. No separate "already saturated" input is needed.
    sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    sum = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/lut_mac_accum.sv
// lut_mac_accum -- sums N_TERMS unsigned 16-bit products per frame and
// presents the frame sum on a valid/ready output.
//
// Build option: LUT_MAC_SAT_EN (saturating accumulate, see lut_mac_addsat).
//
// Parameters:
//   N_TERMS  products per frame, 1..255
//   ACC_W    accumulator / output width, 16..32
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   product input handshake
//   in_prod  [15:0]     unsigned product
//   out_valid/out_ready frame sum output handshake
//   out_sum  [ACC_W-1:0] frame sum (straight from the acc register)
//   out_ovf             sticky overflow flag for the frame (from ovf register)
//
// Handshake: a transfer happens on a rising clk edge where valid && ready on
// that side. in_ready never depends on in_valid; out_valid never depends on
// out_ready. In HOLD, in_ready follows out_ready so a new frame can start on
// the same edge that drains the previous sum (full throughput).
module lut_mac_accum
  import lut_mult_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS);
  // State entered after the first product of a frame.
  localparam state_t FIRST_NEXT = (N_TERMS == 1) ? HOLD : ACCUM;

  // FSM state is kept as a named enum so checkers can bind to it directly.
  state_t              state, state_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                ovf, ovf_nxt;

  logic [ACC_W-1:0]    add_sum;
  logic                add_carry;
  logic                in_xfer;
  logic                start_frame;
  logic                add_term;

  lut_mac_addsat #(
    .ACC_W(ACC_W)
  ) u_addsat (
    .acc  (acc),
    .prod (in_prod),
    .sum  (add_sum),
    .carry(add_carry)
  );

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    start_frame = 1'b0;
    add_term    = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      ACCUM: begin
        in_ready = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase

    // Reset holds in_ready low even though the state register reads IDLE.
    if (rst) begin
      in_ready = 1'b0;
    end

    in_xfer = in_valid && in_ready;

    case (state)
      IDLE: begin
        start_frame = in_xfer;
      end
      ACCUM: begin
        add_term = in_xfer;
      end
      HOLD: begin
        if (out_ready) begin
          start_frame = in_xfer;
          if (!in_xfer) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (start_frame) begin
      acc_nxt   = ACC_W'(in_prod);
      cnt_nxt   = CNT_ONE;
      ovf_nxt   = 1'b0;
      state_nxt = FIRST_NEXT;
    end

    if (add_term) begin
      acc_nxt = add_sum;
      cnt_nxt = cnt + CNT_ONE;
      ovf_nxt = ovf | add_carry;
      if (cnt + CNT_ONE == CNT_LAST) begin
        state_nxt = HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule
